// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO behind a two-register Wishbone slave.
// DATA (addr[2]=0) pops the head byte; STATUS (addr[2]=1) reports FIFO state and sticky errors.

module wb_uart_rx #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WB_ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
  input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                       wb_we_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  output logic                       wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
  input  logic                       uart_rx_i,
  output logic                       rx_irq_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               rx_sync1;
  logic               rx_sync2;
  logic               rx_prev;
  logic               fall_c;

  logic [CNT_W-1:0]   bit_cnt;
  logic               cnt_zero_c;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;

  logic               load_half_c;
  logic               load_full_c;
  logic               shift_c;
  logic               push_c;
  logic               frame_set_c;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic [LVL_W-1:0]   count_nxt_c;
  logic               full_c;
  logic               not_empty_c;
  logic               wr_en_c;
  logic               pop_c;
  logic               ovr_set_c;

  logic               overrun;
  logic               frame_err;

  logic               req_c;
  logic               rd_req_c;
  logic               clr_c;
  logic [15:0]        status_c;
  logic [WB_DATA_WIDTH-1:0] rdata_c;

  logic               unused_bits;
  assign unused_bits = ^{wb_addr_i, wb_data_i, wb_sel_i};

  // Two-flop synchronizer plus edge-detect flop; all reset low so a line
  // held low through reset must be seen high before a start is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sync1 <= 1'b0;
      rx_sync2 <= 1'b0;
      rx_prev  <= 1'b0;
    end else begin
      rx_sync1 <= uart_rx_i;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign fall_c     = rx_prev & ~rx_sync2;
  assign cnt_zero_c = (bit_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall_c) state_nxt = START;
      START: if (cnt_zero_c) state_nxt = rx_sync2 ? IDLE : DATA;
      DATA:  if (cnt_zero_c && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (cnt_zero_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_half_c = 1'b0;
    load_full_c = 1'b0;
    shift_c     = 1'b0;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    case (state)
      IDLE:  load_half_c = fall_c;
      START: load_full_c = cnt_zero_c & ~rx_sync2;
      DATA: begin
        shift_c     = cnt_zero_c;
        load_full_c = cnt_zero_c;
      end
      STOP: begin
        push_c      = cnt_zero_c & rx_sync2;
        frame_set_c = cnt_zero_c & ~rx_sync2;
      end
      default: ;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (load_half_c) begin
        bit_cnt <= CNT_W'(CLKS_PER_BIT / 2 - 1);
      end else if (load_full_c) begin
        bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
      end else if (!cnt_zero_c) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
      end
      if (load_half_c) begin
        bit_idx <= '0;
      end else if (shift_c) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_c) begin
        shreg <= {rx_sync2, shreg[7:1]};
      end
    end
  end

  assign req_c    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd_req_c = req_c & ~wb_we_i & ~wb_addr_i[2];
  assign clr_c    = req_c & wb_we_i & wb_addr_i[2] & wb_sel_i[0];

  assign full_c      = (count == LVL_W'(FIFO_DEPTH));
  assign not_empty_c = (count != '0);
  assign pop_c       = rd_req_c & not_empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en_c     = push_c & (~full_c | pop_c);
  assign ovr_set_c   = push_c & full_c & ~pop_c;

  always_comb begin
    count_nxt_c = count;
    if (wr_en_c && !pop_c) begin
      count_nxt_c = count + LVL_W'(1);
    end else if (!wr_en_c && pop_c) begin
      count_nxt_c = count - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_irq_o <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_nxt_c;
      rx_irq_o <= (count_nxt_c != '0);
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set_c | (overrun & ~(clr_c & wb_data_i[2]));
      frame_err <= frame_set_c | (frame_err & ~(clr_c & wb_data_i[3]));
    end
  end

  assign status_c = {8'(count), 4'b0000, frame_err, overrun, full_c, not_empty_c};

  always_comb begin
    rdata_c = '0;
    if (wb_addr_i[2]) begin
      rdata_c = WB_DATA_WIDTH'(status_c);
    end else if (not_empty_c) begin
      rdata_c = WB_DATA_WIDTH'(mem[rd_ptr]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      wb_ack_o  <= req_c;
      wb_data_o <= (req_c && !wb_we_i) ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: serial frames in, Wishbone reads out, bytes
// checked against a queue scoreboard and a small status model.

module tb_wb_uart_rx;

  localparam int unsigned C     = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic        rx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  bit           m_ovr;
  bit           m_ferr;

  always #5 clk = ~clk;

  wb_uart_rx #(
    .WB_DATA_WIDTH(32),
    .WB_ADDR_WIDTH(32),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_addr_i(wb_addr),
    .wb_data_i(wb_wdata),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_ack_o (wb_ack),
    .wb_data_o(wb_rdata),
    .uart_rx_i(rx),
    .rx_irq_o (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(exp_q.size());
    return {16'h0000, cnt, 4'h0, m_ferr, m_ovr, 1'(exp_q.size() == DEPTH), 1'(exp_q.size() != 0)};
  endfunction

  // Called aligned to posedge+1; every line change stays on that grid.
  task automatic send_byte(input byte unsigned b, input bit stop);
    rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(C);
    end
    rx = stop;
    wait_cycles(C);
    rx = 1'b1;
  endtask

  task automatic wb_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, output logic [31:0] rdata);
    bit got;
    got      = 1'b0;
    rdata    = '0;
    wb_addr  = addr;
    wb_wdata = wdata;
    wb_sel   = sel;
    wb_we    = we;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        got   = 1'b1;
        rdata = wb_rdata;
      end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    check("wb_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    wb_access(1'b0, 32'h4, 32'h0, 4'hf, d);
    check(tag, d, model_status());
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = 32'h0;
    if (exp_q.size() != 0) exp = 32'(exp_q.pop_front());
    wb_access(1'b0, 32'h0, 32'h0, 4'hf, d);
    check(tag, d, exp);
  endtask

  task automatic write_status(input logic [31:0] v, input logic [3:0] sel);
    logic [31:0] d;
    wb_access(1'b1, 32'h4, v, sel, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    wb_addr  = '0;
    wb_wdata = '0;
    wb_sel   = '0;
    wb_we    = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;

    wait_cycles(3);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_data", wb_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    wait_cycles(5);

    // 0xA5: irq rises on edge 155 after the line falls (2 sync + 152 to stop sample + 1)
    fork
      send_byte(8'hA5, 1'b1);
      begin
        wait_cycles(154);
        check("irq_before_stop", 32'(irq), 32'd0);
        wait_cycles(1);
        check("irq_after_stop", 32'(irq), 32'd1);
      end
    join
    model_push(8'hA5);
    wait_cycles(C);
    read_status("status_a5");
    read_data("data_a5");
    check("irq_after_pop", 32'(irq), 32'd0);

    // Short low glitch is rejected at the start-bit midpoint
    rx = 1'b0;
    wait_cycles(6);
    rx = 1'b1;
    wait_cycles(3 * C);
    read_status("status_glitch");
    check("irq_glitch", 32'(irq), 32'd0);

    // Framing error, then W1C with and without byte lane 0
    send_byte(8'h3C, 1'b0);
    m_ferr = 1'b1;
    wait_cycles(2 * C);
    read_status("status_ferr");
    write_status(32'h8, 4'h0);
    read_status("status_ferr_sel0");
    write_status(32'h8, 4'h1);
    m_ferr = 1'b0;
    read_status("status_ferr_clr");

    // Overflow: five bytes into a four-deep FIFO
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b), 1'b1);
      model_push(8'(b));
    end
    wait_cycles(2 * C);
    read_status("status_overrun");
    for (int i = 0; i < 5; i++) read_data("data_overrun_drain");
    write_status(32'h4, 4'h1);
    m_ovr = 1'b0;
    read_status("status_ovr_clr");

    // Pop lands in the exact cycle of a push into a full FIFO
    for (int b = 8'h11; b <= 8'h14; b++) begin
      send_byte(8'(b), 1'b1);
      model_push(8'(b));
    end
    fork
      send_byte(8'h15, 1'b1);
      begin
        wait_cycles(154);
        read_data("data_pop_at_push");
      end
    join
    model_push(8'h15);
    wait_cycles(C);
    read_status("status_pop_at_push");
    for (int i = 0; i < 4; i++) read_data("data_pop_at_push_drain");

    // Reset during bit 4 of a frame; upper nibble zero keeps the line low until the stop bit
    send_byte(8'h77, 1'b1);
    model_push(8'h77);
    wait_cycles(C);
    check("irq_pending_pre_rst", 32'(irq), 32'd1);
    fork
      send_byte(8'h0F, 1'b1);
      begin
        wait_cycles(5 * C + 2);
        rst = 1'b1;
        wait_cycles(2);
        check("midrst_ack", 32'(wb_ack), 32'd0);
        check("midrst_data", wb_rdata, 32'h0);
        check("midrst_irq", 32'(irq), 32'd0);
        wait_cycles(2);
        rst = 1'b0;
      end
    join
    exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_cycles(2 * C);
    read_status("status_after_rst");
    send_byte(8'h5A, 1'b1);
    model_push(8'h5A);
    wait_cycles(C);
    read_status("status_5a");
    read_data("data_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
